// File: rtl/pb_event_pkg.sv
// pb_event_pkg: shared event-kind and hold-FSM state encodings for the push-button event path
package pb_event_pkg;

   localparam logic [1:0] EVT_PRESS   = 2'b00;
   localparam logic [1:0] EVT_REPEAT  = 2'b01;
   localparam logic [1:0] EVT_RELEASE = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_RPT  = 2'd2;

   // Index arithmetic for the round-robin scan over n channels
   function automatic int wrap_add(input int a, input int b, input int n);
      return (a + b) % n;
   endfunction

endpackage

// File: rtl/pb_hold_timer.sv
// pb_hold_timer: per-button edge detect, hold/auto-repeat FSM, one-cycle event strobe
module pb_hold_timer
   import pb_event_pkg::*;
#(
   parameter int CNT_W         = 24,
   parameter int HOLD_CYCLES   = 13_500_000,
   parameter int REPEAT_CYCLES = 2_700_000
) (
   input  logic       clock27MHz,
   input  logic       reset_n,
   input  logic       btn,
   input  logic       repeat_en,
   output logic       evt_stb,
   output logic [1:0] evt_kind
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   logic             prev;
   logic             prs;
   logic             rel;
   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   assign prs = btn & ~prev;
   assign rel = ~btn & prev;

   // Next state and event strobe; a release beats any terminal count in the same cycle
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      evt_stb   = 1'b0;
      evt_kind  = EVT_PRESS;
      if (rel) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
         evt_stb   = 1'b1;
         evt_kind  = EVT_RELEASE;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt_nxt = '0;
               if (prs) begin
                  state_nxt = ST_HOLD;
                  evt_stb   = 1'b1;
               end
            end
            ST_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state_nxt = ST_RPT;
                  cnt_nxt   = '0;
                  evt_stb   = repeat_en;
                  evt_kind  = EVT_REPEAT;
               end
            end
            ST_RPT: begin
               if (cnt == RPT_LAST) begin
                  cnt_nxt  = '0;
                  evt_stb  = repeat_en;
                  evt_kind = EVT_REPEAT;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Previous-level register, FSM state and hold/repeat counter
   always_ff @(posedge clock27MHz or negedge reset_n) begin
      if (!reset_n) begin
         prev  <= 1'b0;
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         prev  <= btn;
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: rtl/pushbutton_event_arbiter.sv
// pushbutton_event_arbiter: per-button event slots, overrun flags and round-robin valid/ready output
module pushbutton_event_arbiter
   import pb_event_pkg::*;
#(
   parameter  int NUM_BTN       = 4,
   parameter  int CNT_W         = 24,
   parameter  int HOLD_CYCLES   = 13_500_000,
   parameter  int REPEAT_CYCLES = 2_700_000,
   localparam int ID_W          = $clog2(NUM_BTN)
) (
   input  logic               clock27MHz,
   input  logic               reset_n,
   input  logic [NUM_BTN-1:0] btn_state,
   input  logic [NUM_BTN-1:0] repeat_en,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [ID_W-1:0]    evt_id,
   output logic [1:0]         evt_kind,
   output logic [NUM_BTN-1:0] overrun,
   input  logic               overrun_clr
);

   logic [NUM_BTN-1:0]      stb;
   logic [NUM_BTN-1:0][1:0] kind;
   logic [NUM_BTN-1:0]      pend;
   logic [NUM_BTN-1:0][1:0] pkind;
   logic [NUM_BTN-1:0]      take;
   logic [NUM_BTN-1:0]      ovr_set;
   logic [ID_W-1:0]         rr_ptr;
   logic [ID_W-1:0]         win;
   logic                    found;
   logic                    load;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      pb_hold_timer #(
         .CNT_W         (CNT_W),
         .HOLD_CYCLES   (HOLD_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES)
      ) u_timer (
         .clock27MHz (clock27MHz),
         .reset_n    (reset_n),
         .btn        (btn_state[i]),
         .repeat_en  (repeat_en[i]),
         .evt_stb    (stb[i]),
         .evt_kind   (kind[i])
      );
   end

   assign load = !evt_valid || evt_ready;

   // Round-robin pick: scanning downward leaves the first pending slot at or after rr_ptr
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = NUM_BTN - 1; k >= 0; k--) begin
         if (pend[ID_W'(wrap_add(int'(rr_ptr), k, NUM_BTN))]) begin
            found = 1'b1;
            win   = ID_W'(wrap_add(int'(rr_ptr), k, NUM_BTN));
         end
      end
   end

   // Slot being emptied this cycle, and collisions that lose an event
   always_comb begin
      take    = '0;
      ovr_set = '0;
      for (int k = 0; k < NUM_BTN; k++) begin
         take[k]    = load && found && (win == ID_W'(k));
         ovr_set[k] = stb[k] && pend[k] && !take[k] &&
                      !(kind[k] == EVT_RELEASE && pkind[k] == EVT_REPEAT);
      end
   end

   // Pending slots: fill when free or draining, let RELEASE replace a stale REPEAT; sticky overrun
   always_ff @(posedge clock27MHz or negedge reset_n) begin
      if (!reset_n) begin
         pend    <= '0;
         pkind   <= '0;
         overrun <= '0;
      end else begin
         for (int k = 0; k < NUM_BTN; k++) begin
            if (stb[k] && (!pend[k] || take[k])) begin
               pend[k]  <= 1'b1;
               pkind[k] <= kind[k];
            end else if (stb[k] && kind[k] == EVT_RELEASE && pkind[k] == EVT_REPEAT) begin
               pkind[k] <= EVT_RELEASE;
            end else if (take[k]) begin
               pend[k] <= 1'b0;
            end
         end
         overrun <= (overrun & ~{NUM_BTN{overrun_clr}}) | ovr_set;
      end
   end

   // Output register and round-robin pointer; contents frozen while the consumer stalls
   always_ff @(posedge clock27MHz or negedge reset_n) begin
      if (!reset_n) begin
         evt_valid <= 1'b0;
         evt_id    <= '0;
         evt_kind  <= EVT_PRESS;
         rr_ptr    <= '0;
      end else if (load) begin
         evt_valid <= found;
         if (found) begin
            evt_id   <= win;
            evt_kind <= pkind[win];
            rr_ptr   <= ID_W'(wrap_add(int'(win), 1, NUM_BTN));
         end
      end
   end

endmodule

// File: tb/tb_pushbutton_event_arbiter.sv
// tb_pushbutton_event_arbiter: directed scenarios checked against a rule-level behavioural model
module tb_pushbutton_event_arbiter;

   localparam int N    = 4;
   localparam int HOLD = 8;
   localparam int RPT  = 4;

   logic       clk         = 1'b0;
   logic       reset_n     = 1'b1;
   logic [3:0] btn_state   = '0;
   logic [3:0] repeat_en   = '0;
   logic       evt_ready   = 1'b0;
   logic       overrun_clr = 1'b0;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic [1:0] evt_kind;
   logic [3:0] overrun;

   always #5 clk = ~clk;

   pushbutton_event_arbiter #(
      .NUM_BTN       (N),
      .CNT_W         (4),
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (RPT)
   ) dut (
      .clock27MHz  (clk),
      .reset_n     (reset_n),
      .btn_state   (btn_state),
      .repeat_en   (repeat_en),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_id      (evt_id),
      .evt_kind    (evt_kind),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: events from press/release times and held duration, a per-button
   // one-deep mailbox, and a rotating-priority output register
   int       cyc = 0;
   bit [3:0] m_prev = '0, m_held = '0, m_pend = '0, m_ovr = '0;
   int       m_t0 [N];
   int       m_pk [N];
   bit       m_valid = 1'b0;
   int       m_id = 0, m_kind = 0, m_rr = 0;
   int       log_id[$], log_kind[$], log_cyc[$];

   task automatic model_step();
      int       w;
      int       ev;
      int       d;
      bit [3:0] setov;
      if (m_valid && evt_ready) begin
         log_id.push_back(m_id);
         log_kind.push_back(m_kind);
         log_cyc.push_back(cyc);
      end
      if (!m_valid || evt_ready) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && m_pend[(m_rr + k) % N]) w = (m_rr + k) % N;
         m_valid = (w >= 0);
         if (w >= 0) begin
            m_id      = w;
            m_kind    = m_pk[w];
            m_pend[w] = 1'b0;
            m_rr      = (w + 1) % N;
         end
      end
      setov = '0;
      for (int i = 0; i < N; i++) begin
         ev = -1;
         d  = cyc - m_t0[i];
         if (!btn_state[i] && m_prev[i]) begin
            ev        = 2;
            m_held[i] = 1'b0;
         end else if (btn_state[i] && !m_prev[i]) begin
            ev        = 0;
            m_held[i] = 1'b1;
            m_t0[i]   = cyc;
         end else if (m_held[i] && repeat_en[i] && d >= HOLD && (d - HOLD) % RPT == 0) begin
            ev = 1;
         end
         if (ev >= 0) begin
            if (!m_pend[i]) begin
               m_pend[i] = 1'b1;
               m_pk[i]   = ev;
            end else if (ev == 2 && m_pk[i] == 1) begin
               m_pk[i] = 2;
            end else begin
               setov[i] = 1'b1;
            end
         end
      end
      m_ovr  = (overrun_clr ? 4'b0 : m_ovr) | setov;
      m_prev = btn_state;
      cyc++;
   endtask

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         m_prev  = '0;
         m_held  = '0;
         m_pend  = '0;
         m_ovr   = '0;
         m_valid = 1'b0;
         m_id    = 0;
         m_kind  = 0;
         m_rr    = 0;
      end else begin
         model_step();
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   initial forever begin
      @(negedge clk);
      chk("evt_valid", evt_valid, m_valid);
      if (m_valid) begin
         chk("evt_id", evt_id, m_id);
         chk("evt_kind", evt_kind, m_kind);
      end
      chk("overrun", overrun, m_ovr);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      log_id.delete();
      log_kind.delete();
      log_cyc.delete();
   endtask

   task automatic chk_beat(input string tag, input int idx, input int id, input int kind);
      chk({tag, " id"}, idx < log_id.size() ? log_id[idx] : -1, id);
      chk({tag, " kind"}, idx < log_kind.size() ? log_kind[idx] : -1, kind);
   endtask

   int exp_gap [4] = '{8, 12, 16, 20};

   initial begin
      #1 reset_n = 1'b0;
      step(3);
      chk("rst evt_valid", evt_valid, 0);
      chk("rst evt_id", evt_id, 0);
      chk("rst evt_kind", evt_kind, 0);
      chk("rst overrun", overrun, 0);
      reset_n = 1'b1;
      step(2);

      // Simultaneous press then release of buttons 0 and 3, pointer starting at 0
      evt_ready = 1'b1;
      clear_log();
      btn_state = 4'b1001;
      step(4);
      btn_state = 4'b0000;
      step(4);
      chk("t3 beats", log_id.size(), 4);
      chk_beat("t3 b0", 0, 0, 0);
      chk_beat("t3 b1", 1, 3, 0);
      chk_beat("t3 b2", 2, 0, 2);
      chk_beat("t3 b3", 3, 3, 2);
      chk("t3 back-to-back", log_cyc.size() > 1 ? log_cyc[1] - log_cyc[0] : -1, 1);

      // Single press on button 2: two-cycle latency, one-cycle beat
      clear_log();
      btn_state[2] = 1'b1;
      step(2);
      chk("t1 valid", evt_valid, 1);
      chk("t1 id", evt_id, 2);
      chk("t1 kind", evt_kind, 0);
      step(1);
      chk("t1 valid drop", evt_valid, 0);
      btn_state[2] = 1'b0;
      step(4);
      chk("t1 beats", log_id.size(), 2);
      chk_beat("t1 b0", 0, 2, 0);
      chk_beat("t1 b1", 1, 2, 2);

      // Auto-repeat on button 1
      clear_log();
      repeat_en    = 4'b0010;
      btn_state[1] = 1'b1;
      step(21);
      btn_state[1] = 1'b0;
      step(4);
      repeat_en = 4'b0000;
      chk("t2 beats", log_id.size(), 6);
      chk_beat("t2 press", 0, 1, 0);
      for (int k = 1; k <= 4; k++) begin
         chk_beat("t2 repeat", k, 1, 1);
         chk("t2 gap", log_cyc.size() > k ? log_cyc[k] - log_cyc[0] : -1, exp_gap[k-1]);
      end
      chk_beat("t2 release", 5, 1, 2);
      chk("t2 overrun", overrun, 0);

      // Back-pressure holds the presented event stable
      clear_log();
      evt_ready = 1'b0;
      btn_state = 4'b0011;
      step(2);
      for (int k = 0; k < 10; k++) begin
         chk("t4 hold valid", evt_valid, 1);
         chk("t4 hold id", evt_id, 0);
         chk("t4 hold kind", evt_kind, 0);
         step(1);
      end
      evt_ready = 1'b1;
      step(1);
      chk("t4 next valid", evt_valid, 1);
      chk("t4 next id", evt_id, 1);
      chk("t4 next kind", evt_kind, 0);
      btn_state = 4'b0000;
      step(6);
      chk("t4 beats", log_id.size(), 4);
      chk_beat("t4 b0", 0, 0, 0);
      chk_beat("t4 b1", 1, 1, 0);
      chk_beat("t4 b2", 2, 0, 2);
      chk_beat("t4 b3", 3, 1, 2);

      // Dropped press on button 2 sets overrun; clear afterwards
      clear_log();
      evt_ready    = 1'b0;
      btn_state[2] = 1'b1;
      step(3);
      btn_state[2] = 1'b0;
      step(2);
      btn_state[2] = 1'b1;
      step(2);
      chk("t5 overrun set", overrun, 4);
      evt_ready = 1'b1;
      step(4);
      chk("t5 beats", log_id.size(), 2);
      chk_beat("t5 b0", 0, 2, 0);
      chk_beat("t5 b1", 1, 2, 2);
      chk("t5 overrun sticky", overrun, 4);
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
      chk("t5 overrun clr", overrun, 0);
      btn_state[2] = 1'b0;
      step(4);

      // Asynchronous reset mid-handshake, button 0 held through reset
      evt_ready = 1'b0;
      btn_state = 4'b0001;
      step(3);
      chk("t6 pre valid", evt_valid, 1);
      #2 reset_n = 1'b0;
      #1 chk("t6 async drop", evt_valid, 0);
      step(3);
      #2 reset_n = 1'b1;
      step(1);
      chk("t6 first cycle", evt_valid, 0);
      step(1);
      chk("t6 valid", evt_valid, 1);
      chk("t6 id", evt_id, 0);
      chk("t6 kind", evt_kind, 0);

      evt_ready = 1'b1;
      btn_state = 4'b0000;
      step(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pushbutton_event_arbiter.md
# pushbutton_event_arbiter

Turns the debounced push-button levels into a single stream of button events for the processor's input port. Each `PushButton_Debouncer` output feeds one channel. Per button, the block detects presses and releases and generates auto-repeat events while a button is held. A round-robin arbiter delivers one event at a time over a valid/ready handshake.

## Interface
Parameters:
- `NUM_BTN`, default 4: number of button channels, must be ≥ 2.
- `CNT_W`, default 24: width of the hold/repeat counter. It must hold `HOLD_CYCLES-1`.
- `HOLD_CYCLES`, default 13_500_000: press-to-first-repeat delay, 0.5 s at 27 MHz.
- `REPEAT_CYCLES`, default 2_700_000: repeat period, 0.1 s. It must be ≤ 2^CNT_W.
- `ID_W`: localparam, equal to $clog2(NUM_BTN).

Ports:
- `clock27MHz`  in  1: the single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `btn_state`  in  NUM_BTN: debounced levels, 1 = pressed, synchronous to `clock27MHz`.
- `repeat_en`  in  NUM_BTN: per-button auto-repeat enable.
- `evt_valid`  out  1: an event is presented.
- `evt_ready`  in  1: the consumer accepts the presented event.
- `evt_id`  out  ID_W: button index of the presented event.
- `evt_kind`  out  2: 00 = PRESS, 01 = REPEAT, 10 = RELEASE.
- `overrun`  out  NUM_BTN: sticky per-button flag, set when an event was dropped.
- `overrun_clr`  in  1: synchronous clear of all `overrun` bits.

## Operation
Edge detection, per button i:
- `prev[i]` registers `btn_state[i]` every cycle.
- press = `btn_state & ~prev`; release = `~btn_state & prev`.

Hold FSM, one per button, with states IDLE, HOLD and RPT and a counter `cnt` of width CNT_W:
- IDLE: on press, go to HOLD, clear `cnt`, raise a PRESS event.
- HOLD: increment `cnt` each cycle. When `cnt == HOLD_CYCLES-1`, go to RPT, clear `cnt`, and raise a REPEAT event if `repeat_en[i]` is high.
- RPT: increment `cnt`. When `cnt == REPEAT_CYCLES-1`, clear `cnt` and raise a REPEAT event if `repeat_en[i]` is high. With `repeat_en` low, the FSM still cycles but emits nothing.
- Any state: a release forces IDLE, clears `cnt` and raises a RELEASE event. Release has priority over a terminal count in the same cycle.

Pending slot, one per button, holding a valid bit and a 2-bit kind:
- A new event is stored if the slot is empty, or if the slot is being loaded into the output this cycle.
- A RELEASE overwrites a pending REPEAT without setting overrun.
- Any other collision drops the new event and sets `overrun[i]`.
- When a set and `overrun_clr` hit the same bit in the same cycle, the set wins.

Arbiter and output register:
- The output register loads when `!evt_valid || evt_ready`.
- Winner: the first pending slot scanning from `rr_ptr` upward, modulo NUM_BTN.
- On a load: the winner's slot is cleared, `evt_id` and `evt_kind` take the winner's values, and `rr_ptr` becomes winner+1 modulo NUM_BTN.
- If nothing is pending on a load cycle, `evt_valid` falls to 0.
- While `evt_valid && !evt_ready`, `evt_valid`, `evt_id` and `evt_kind` hold stable.

## Timing
- Reset values: `evt_valid`=0, `evt_id`=0, `evt_kind`=00, `overrun`=0. Internally, `prev`=0, all FSMs in IDLE, slots empty, `rr_ptr`=0.
- A button held through reset therefore yields a PRESS on the first cycle after reset is released.
- Latency: `btn_state` changes before edge E0, the slot is set at E0, and `evt_valid` is high after E1. This gives 2 cycles with the consumer idle.
- Throughput: one event per cycle while `evt_ready` is held high.
- First REPEAT comes HOLD_CYCLES cycles after the PRESS slot-set. Later REPEATs come every REPEAT_CYCLES cycles.
- Asserting `reset_n` low mid-handshake drops `evt_valid` immediately, without waiting for a clock edge. The presented event is lost.

## Structure
- Shared package `pb_event_pkg` holds:
  - event kind encodings EVT_PRESS, EVT_REPEAT, EVT_RELEASE;
  - hold-FSM state encodings ST_IDLE, ST_HOLD, ST_RPT.
- Sub-module `pb_hold_timer`: the per-button edge detect, hold FSM and counter, emitting a one-cycle `evt_stb` and `evt_kind`. It is instantiated NUM_BTN times.
- The top level holds the pending slots, overrun flags, round-robin arbiter and output register.

## Test plan
All scenarios use NUM_BTN=4, HOLD_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4.
1. Button 2 pressed, `evt_ready`=1 → two cycles later one beat with id=2, kind=00. `evt_valid` lasts exactly one cycle.
2. Button 1 held 20 cycles with `repeat_en[1]`=1 → events in order: PRESS, then REPEATs 8, 12, 16 and 20 cycles after the PRESS slot-set, then RELEASE. No `overrun`.
3. Buttons 0 and 3 pressed in the same cycle, `rr_ptr`=0 → id 0 then id 3 on consecutive beats. A following simultaneous release of both yields RELEASE id 0 then id 3, since `rr_ptr` has wrapped to 0.
4. `evt_ready`=0 with buttons 0 and 1 pressed → id 0 PRESS held stable for 10 cycles. After `evt_ready` rises, id 1 PRESS follows on the next beat.
5. `evt_ready`=0 with press, release and press on button 2 → `overrun[2]`=1. After `evt_ready` rises: PRESS, RELEASE. Then pulse `overrun_clr` → `overrun`=0.
6. Assert `reset_n` low while `evt_valid`=1 → `evt_valid`=0 asynchronously. With button 0 held through reset, a PRESS id 0 appears 2 cycles after reset is released.
